// File: rtl/param_element_counter.sv
// Splits a vector op of vl elements into per-lane micro-ops; first uop_valid one cycle after de_en.
// stall holds the current micro-op in place; ex_return restarts from reset_idx with top priority.
module param_element_counter #(
  parameter int NUM_LANES = 2,
  parameter int OFFSET_W  = 32,
  localparam int MAX_EPU  = 4 * NUM_LANES,
  localparam int CNT_W    = $clog2(MAX_EPU + 1)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                de_en,
  input  logic [OFFSET_W-1:0] vstart,
  input  logic [OFFSET_W-1:0] vl,
  input  logic [1:0]          sew,
  input  logic                stall,
  input  logic                ex_return,
  input  logic [OFFSET_W-1:0] reset_idx,
  output logic                uop_valid,
  output logic [OFFSET_W-1:0] offset,
  output logic [CNT_W-1:0]    uop_cnt,
  output logic [MAX_EPU-1:0]  elem_mask,
  output logic                done,
  output logic                busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state;
  logic [OFFSET_W-1:0] offset_r;
  logic [OFFSET_W-1:0] vl_r;
  logic [1:0]          sew_r;

  logic [OFFSET_W-1:0] epu;
  logic [OFFSET_W-1:0] remaining;
  logic                run;

  always_comb begin
    case (sew_r)
      2'b00:   epu = OFFSET_W'(NUM_LANES * 4);
      2'b01:   epu = OFFSET_W'(NUM_LANES * 2);
      default: epu = OFFSET_W'(NUM_LANES);
    endcase
  end

  assign run       = (state == RUN);
  assign remaining = vl_r - offset_r;
  assign uop_valid = run;
  assign busy      = run;
  assign offset    = offset_r;
  assign done      = run && (remaining <= epu);

  always_comb begin
    uop_cnt = '0;
    if (run)
      uop_cnt = (remaining < epu) ? CNT_W'(remaining) : CNT_W'(epu);
  end

  // Thermometer mask: lane slots below uop_cnt carry live elements.
  always_comb begin
    elem_mask = '0;
    for (int i = 0; i < MAX_EPU; i++)
      elem_mask[i] = (CNT_W'(i) < uop_cnt);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      offset_r <= '0;
      vl_r     <= '0;
      sew_r    <= 2'b10;
    end else if (ex_return) begin
      offset_r <= reset_idx;
      state    <= (reset_idx < vl_r) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (de_en && (vstart < vl)) begin
            vl_r     <= vl;
            sew_r    <= sew;
            offset_r <= vstart;
            state    <= RUN;
          end
        end
        default: begin
          // remaining > epu on a non-final step, so this add cannot pass vl_r.
          if (!stall) begin
            if (done) state <= IDLE;
            else      offset_r <= offset_r + epu;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_element_counter.sv
// Directed and random checks of param_element_counter against a queue-of-offsets reference model.
module tb_param_element_counter;

  localparam int NL = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        de_en;
  logic [31:0] vstart;
  logic [31:0] vl;
  logic [1:0]  sew;
  logic        stall;
  logic        ex_return;
  logic [31:0] reset_idx;
  logic        uop_valid;
  logic [31:0] offset;
  logic [3:0]  uop_cnt;
  logic [7:0]  elem_mask;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: the pending micro-op offsets, plus what offset_r should read.
  logic [31:0] mq[$];
  logic [31:0] last_off;
  logic [31:0] m_vl;
  int          m_epu;

  param_element_counter #(.NUM_LANES(NL), .OFFSET_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .de_en(de_en), .vstart(vstart), .vl(vl), .sew(sew),
    .stall(stall), .ex_return(ex_return), .reset_idx(reset_idx),
    .uop_valid(uop_valid), .offset(offset), .uop_cnt(uop_cnt), .elem_mask(elem_mask),
    .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic int epu_of(input logic [1:0] s);
    return (s == 2'b00) ? 4 * NL : (s == 2'b01) ? 2 * NL : NL;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [31:0] start, input logic [31:0] len, input int e);
    mq.delete();
    for (longint o = start; o < len; o += e) mq.push_back(32'(o));
  endtask

  task automatic model_reset();
    mq.delete();
    last_off = '0;
    m_vl     = '0;
    m_epu    = NL;
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] ecnt;
    logic [63:0] emask;
    ecnt = 0;
    if (mq.size() > 0) begin
      ecnt = 64'(m_vl - mq[0]);
      if (ecnt > 64'(m_epu)) ecnt = 64'(m_epu);
    end
    emask = (64'd1 << ecnt) - 64'd1;
    chk({tag, ".uop_valid"}, 64'(uop_valid), 64'(mq.size() > 0));
    chk({tag, ".busy"},      64'(busy),      64'(mq.size() > 0));
    chk({tag, ".offset"},    64'(offset),    64'(last_off));
    chk({tag, ".uop_cnt"},   64'(uop_cnt),   ecnt);
    chk({tag, ".elem_mask"}, 64'(elem_mask), emask);
    chk({tag, ".done"},      64'(done),      64'(mq.size() == 1));
  endtask

  // Check the current outputs, then clock one edge with the given inputs and advance the model.
  task automatic cyc(input string tag, input logic d, input logic [31:0] vs, input logic [31:0] vln,
                     input logic [1:0] sw, input logic st, input logic ex, input logic [31:0] ri);
    de_en = d; vstart = vs; vl = vln; sew = sw; stall = st; ex_return = ex; reset_idx = ri;
    check_outputs(tag);
    @(posedge CLK);
    if (!nRST) model_reset();
    else if (ex) begin
      build(ri, m_vl, m_epu);
      last_off = ri;
    end else if (mq.size() == 0) begin
      if (d && vs < vln) begin
        m_vl = vln;
        m_epu = epu_of(sw);
        build(vs, vln, m_epu);
        last_off = vs;
      end
    end else if (!st) begin
      void'(mq.pop_front());
      if (mq.size() > 0) last_off = mq[0];
    end
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] e_off[3];
    logic [3:0]  e_cnt[3];
    logic [7:0]  e_msk[3];
    e_off = '{32'd0, 32'd2, 32'd4};
    e_cnt = '{4'd2, 4'd2, 4'd1};
    e_msk = '{8'h03, 8'h03, 8'h01};

    nRST = 1'b0; de_en = 0; vstart = 0; vl = 0; sew = 0; stall = 0; ex_return = 0; reset_idx = 0;
    model_reset();
    #1;
    chk("rst.uop_valid", 64'(uop_valid), 64'd0);
    chk("rst.offset",    64'(offset),    64'd0);
    chk("rst.elem_mask", 64'(elem_mask), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    idle("post_rst");
    idle("post_rst2");

    // sew=32, vl=5: offsets 0,2,4 with counts 2,2,1, also checked against fixed values.
    cyc("s32_start", 1'b1, 32'd0, 32'd5, 2'b10, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("s32.offset",    64'(offset),    64'(e_off[i]));
      chk("s32.uop_cnt",   64'(uop_cnt),   64'(e_cnt[i]));
      chk("s32.elem_mask", 64'(elem_mask), 64'(e_msk[i]));
      chk("s32.done",      64'(done),      64'(i == 2));
      idle("s32_run");
    end
    idle("s32_after");

    cyc("s8_start", 1'b1, 32'd0, 32'd10, 2'b00, 1'b0, 1'b0, 32'd0);
    chk("s8.first_mask", 64'(elem_mask), 64'hFF);
    for (int i = 0; i < 3; i++) idle("s8_run");

    cyc("empty_start", 1'b1, 32'd3, 32'd3, 2'b01, 1'b0, 1'b0, 32'd0);
    chk("empty.busy", 64'(busy), 64'd0);
    idle("empty_after");

    // Stall three cycles at offset 2, then resume.
    cyc("stall_start", 1'b1, 32'd0, 32'd8, 2'b10, 1'b0, 1'b0, 32'd0);
    idle("stall_o0");
    for (int i = 0; i < 3; i++) cyc("stall_hold", 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) idle("stall_resume");

    // ex_return to 5 while stalled at offset 2.
    cyc("exr_start", 1'b1, 32'd0, 32'd8, 2'b10, 1'b0, 1'b0, 32'd0);
    idle("exr_o0");
    cyc("exr_hit", 1'b1, 32'd0, 32'd0, 2'b00, 1'b1, 1'b1, 32'd5);
    chk("exr.offset", 64'(offset), 64'd5);
    for (int i = 0; i < 3; i++) idle("exr_run");

    // Asynchronous reset at offset 4, then a clean restart.
    cyc("arst_start", 1'b1, 32'd0, 32'd8, 2'b10, 1'b0, 1'b0, 32'd0);
    idle("arst_o0");
    idle("arst_o2");
    chk("arst.pre_offset", 64'(offset), 64'd4);
    nRST = 1'b0;
    #1;
    model_reset();
    chk("arst.uop_valid", 64'(uop_valid), 64'd0);
    chk("arst.offset",    64'(offset),    64'd0);
    chk("arst.uop_cnt",   64'(uop_cnt),   64'd0);
    chk("arst.done",      64'(done),      64'd0);
    idle("arst_held");
    nRST = 1'b1;
    idle("arst_released");
    cyc("arst_restart", 1'b1, 32'd0, 32'd8, 2'b10, 1'b0, 1'b0, 32'd0);
    chk("arst.restart_offset", 64'(offset), 64'd0);
    for (int i = 0; i < 4; i++) idle("arst_run");

    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          ($urandom_range(0, 9) < 3),
          32'($urandom_range(0, 20)),
          32'($urandom_range(0, 30)),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 19) == 0),
          32'($urandom_range(0, 30)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/param_element_counter.md
PARAM_ELEMENT_COUNTER -- requirements
Module: param_element_counter

Interface
REQ-001 Parameter NUM_LANES, default 2: number of 32-bit datapath lanes.
REQ-002 Parameter OFFSET_W, default 32: width of the element offset and vl/vstart/reset_idx.
REQ-003 Derived MAX_EPU = 4*NUM_LANES (elements per micro-op at SEW=8); CNT_W = clog2(MAX_EPU+1).
REQ-004 Port CLK  in  1  single clock, rising edge.
REQ-005 Port nRST  in  1  reset, asynchronous, active-low.
REQ-006 Port de_en  in  1  start request from decode.
REQ-007 Port vstart  in  OFFSET_W  first element index.
REQ-008 Port vl  in  OFFSET_W  vector length.
REQ-009 Port sew  in  2  element width: 00=8, 01=16, 10=32; 11 treated as 10.
REQ-010 Port stall  in  1  hold the current micro-op.
REQ-011 Port ex_return  in  1  restart from reset_idx after an exception return.
REQ-012 Port reset_idx  in  OFFSET_W  restart element index.
REQ-013 Port uop_valid  out  1  a micro-op is presented this cycle.
REQ-014 Port offset  out  OFFSET_W  first element index of the current micro-op.
REQ-015 Port uop_cnt  out  CNT_W  active elements in the current micro-op.
REQ-016 Port elem_mask  out  MAX_EPU  bit i set iff i < uop_cnt.
REQ-017 Port done  out  1  the current micro-op is the last one.
REQ-018 Port busy  out  1  the FSM is in RUN.

Function
REQ-019 FSM states are IDLE and RUN; registers are state, offset_r, vl_r, sew_r.
REQ-020 Elements per micro-op EPU = NUM_LANES*4 (sew 00), NUM_LANES*2 (01), NUM_LANES (10/11), computed from sew_r.
REQ-021 IDLE, de_en=1, vstart<vl: latch vl_r<=vl, sew_r<=sew, offset_r<=vstart, go to RUN next cycle.
REQ-022 IDLE, de_en=1, vstart>=vl: stay IDLE; no micro-op and no done pulse.
REQ-023 de_en is ignored in RUN.
REQ-024 Outputs are combinational from registers: uop_valid=busy=(state==RUN); offset=offset_r.
REQ-025 In RUN, remaining = vl_r-offset_r (unsigned, OFFSET_W bits) and uop_cnt = min(EPU, remaining).
REQ-026 In RUN, done=1 iff remaining<=EPU; in IDLE, uop_cnt=0, elem_mask=0, done=0.
REQ-027 RUN, stall=0, done=0: offset_r<=offset_r+EPU; stay RUN.
REQ-028 RUN, stall=0, done=1: go to IDLE; offset_r holds its value.
REQ-029 RUN, stall=1: all registers hold, so the outputs are stable.
REQ-030 ex_return=1 has priority over stall and de_en in any state.
REQ-031 ex_return=1: offset_r<=reset_idx; next state is RUN if reset_idx<vl_r, else IDLE; vl_r and sew_r are held.
REQ-032 The offset increment does not wrap, because remaining>EPU guarantees offset_r+EPU<vl_r.
REQ-033 Exactly one micro-op is presented per non-stalled RUN cycle; latency from de_en to the first uop_valid is 1 cycle.

Reset
REQ-034 nRST=0 forces state=IDLE, offset_r=0, vl_r=0, sew_r=2'b10 immediately (asynchronous), including mid-operation.
REQ-035 During reset, uop_valid=busy=done=0, offset=0, uop_cnt=0, elem_mask=0.
REQ-036 After reset deassertion, the block waits for de_en; no micro-op is emitted spontaneously.

Verification (NUM_LANES=2)
REQ-037 sew=10, vstart=0, vl=5, de_en pulse -> offsets 0,2,4; uop_cnt 2,2,1; elem_mask 0x03,0x03,0x01; done on the 3rd; IDLE after.
REQ-038 sew=00, vstart=0, vl=10 -> offsets 0,8; uop_cnt 8,2; elem_mask 0xFF,0x03; done on the 2nd.
REQ-039 sew=01, vstart=3, vl=3 -> no uop_valid, no done, busy stays 0.
REQ-040 sew=10, vl=8, stall=1 for 3 cycles at offset 2 -> offset, uop_cnt and done held; sequence resumes at 4, 6.
REQ-041 sew=10, vl=8, ex_return with reset_idx=5 while at offset 2 (stall=1) -> next offsets 5,7; uop_cnt 2,1; done on offset 7.
REQ-042 nRST low while at offset 4 of vl=8 -> outputs zero at once; after release, a new de_en with vstart=0 restarts at offset 0.
